mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-addressable data memory with word/halfword/byte
// loads and stores, access-fault detection, branch resolution and the
// MEM/WB pipeline register.
module mem_stage #(
  parameter int DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] AddResultIn,
  input  logic        ZeroIn,
  input  logic        BranchSendIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] ReadData2In,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemSignedIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic [4:0]  WriteRegIn,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [4:0]  WriteRegOut,
  output logic        ErrorOut
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          fault;
  logic          wr_en;
  logic [3:0]    byte_en;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [15:0]   half_val;
  logic [7:0]    byte_val;
  logic [31:0]   load_val;

  logic [31:0] read_data_d, read_data_q;
  logic [31:0] alu_result_d, alu_result_q;
  logic        reg_write_d, reg_write_q;
  logic        mem_to_reg_d, mem_to_reg_q;
  logic [4:0]  write_reg_d, write_reg_q;
  logic        error_d, error_q;

  // Branch resolution is purely combinational and ignores reset and faults.
  assign PCSrc        = BranchSendIn & ZeroIn;
  assign BranchTarget = AddResultIn;

  assign word_idx = ALUResultIn[AW+1:2];
  assign lane     = ALUResultIn[1:0];

  // Fault detection: illegal size, misalignment, out-of-range address, or a
  // simultaneous load and store request.
  always_comb begin
    fault = 1'b0;
    if (MemReadIn || MemWriteIn) begin
      if (MemSizeIn == 2'b11)                         fault = 1'b1;
      if (MemSizeIn == 2'b01 && lane[0])              fault = 1'b1;
      if (MemSizeIn == 2'b00 && lane != 2'b00)        fault = 1'b1;
      if (|ALUResultIn[31:AW+2])                      fault = 1'b1;
      if (MemReadIn && MemWriteIn)                    fault = 1'b1;
    end
  end

  // Stores are suppressed while reset is held so an in-flight store is lost.
  assign wr_en = MemWriteIn & ~fault & ~Rst;

  // Lane enables and replicated write data for word/halfword/byte stores.
  always_comb begin
    byte_en = 4'b0000;
    wr_word = ReadData2In;
    case (MemSizeIn)
      2'b00: begin
        byte_en = 4'b1111;
        wr_word = ReadData2In;
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{ReadData2In[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{ReadData2In[7:0]}};
      end
      default: begin
        byte_en = 4'b0000;
        wr_word = ReadData2In;
      end
    endcase
  end

  // One byte-wide memory per lane gives natural per-lane write enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];

    // Lane write; contents are deliberately never reset.
    always_ff @(posedge Clk) begin
      if (wr_en && byte_en[gi]) mem_lane[word_idx] <= wr_word[8*gi +: 8];
    end

    assign rd_word[8*gi +: 8] = mem_lane[word_idx];
  end

  assign rd_shift = rd_word >> {lane, 3'b000};
  assign half_val = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_val = rd_shift[7:0];

  // Sub-word extraction with sign or zero extension.
  always_comb begin
    load_val = 32'h0;
    case (MemSizeIn)
      2'b00:   load_val = rd_word;
      2'b01:   load_val = {{16{MemSignedIn & half_val[15]}}, half_val};
      2'b10:   load_val = {{24{MemSignedIn & byte_val[7]}}, byte_val};
      default: load_val = 32'h0;
    endcase
  end

  // Next-state values for the MEM/WB register.
  always_comb begin
    read_data_d  = (MemReadIn && !fault) ? load_val : 32'h0;
    alu_result_d = ALUResultIn;
    reg_write_d  = RegWriteIn & ~fault;
    mem_to_reg_d = MemToRegIn;
    write_reg_d  = WriteRegIn;
    error_d      = fault;
  end

  // MEM/WB register, cleared asynchronously by reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      write_reg_q  <= 5'd0;
      error_q      <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      write_reg_q  <= write_reg_d;
      error_q      <= error_d;
    end
  end

  assign ReadDataOut  = read_data_q;
  assign ALUResultOut = alu_result_q;
  assign RegWriteOut  = reg_write_q;
  assign MemToRegOut  = mem_to_reg_q;
  assign WriteRegOut  = write_reg_q;
  assign ErrorOut     = error_q;

endmodule
